// File: rtl/seg7_scan_driver.sv
// Registered anode/cathode driver for a 4-digit seven-segment display:
// hex decode, anti-ghosting blank time after each select change, PWM dimming.
module seg7_scan_driver #(
  parameter int BLANK_CYCLES = 4,
  parameter int PWM_BITS     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          dnum,
  input  logic                a4,
  input  logic                a5,
  input  logic                a6,
  input  logic                a7,
  input  logic [PWM_BITS-1:0] bright,
  output logic [3:0]          an_n,
  output logic [6:0]          seg_n
);

  localparam int CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

  state_e              state_q, state_d;
  logic [3:0]          sel_q, sel_prev_q, num_q;
  logic [CNT_W-1:0]    blank_cnt_q, blank_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                sel_ok, chg, pwm_on;
  logic [3:0]          an_d;
  logic [6:0]          seg_d;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign sel_ok = (sel_q != 4'b0000) && ((sel_q & (sel_q - 4'd1)) == 4'b0000);
  assign chg    = (sel_q != sel_prev_q);
  assign pwm_on = (bright == {PWM_BITS{1'b1}}) || (pwm_cnt_q < bright);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q      <= 4'b0000;
      sel_prev_q <= 4'b0000;
      num_q      <= 4'h0;
      pwm_cnt_q  <= '0;
    end else begin
      sel_q      <= {a7, a6, a5, a4};
      sel_prev_q <= sel_q;
      num_q      <= dnum;
      pwm_cnt_q  <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      blank_cnt_q <= '0;
      an_n        <= 4'hF;
      seg_n       <= 7'h7F;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      an_n        <= an_d;
      seg_n       <= seg_d;
    end
  end

  // Invalid select beats a select change, which beats counter expiry.
  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_ok) begin
          if (BLANK_CYCLES == 0) begin
            state_d = SHOW;
          end else begin
            state_d     = BLANK;
            blank_cnt_d = CNT_LOAD;
          end
        end
      end
      BLANK: begin
        if (!sel_ok) begin
          state_d = IDLE;
        end else if (chg) begin
          blank_cnt_d = CNT_LOAD;
        end else begin
          blank_cnt_d = blank_cnt_q - CNT_W'(1);
          if (blank_cnt_q == CNT_W'(1)) state_d = SHOW;
        end
      end
      SHOW: begin
        if (!sel_ok) begin
          state_d = IDLE;
        end else if (chg && (BLANK_CYCLES > 0)) begin
          state_d     = BLANK;
          blank_cnt_d = CNT_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come from the next state so the input-to-pin latency is two clocks.
  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    if ((state_d == SHOW) && pwm_on) begin
      an_d  = ~sel_q;
      seg_d = decode(num_q);
    end
  end

endmodule
